// File: rtl/imem_axi_read_master.sv
// -----------------------------------------------------------------------------
// imem_axi_read_master
//
// AXI4 read-only master (Master 0) behind the CPU instruction-fetch port.
// Each fetch request becomes one single-beat INCR read (ARLEN=0, 4-byte beat).
// The fetched word is returned on imem_rdata together with a one-cycle
// imem_rdata_handshake pulse. fetch_stall holds the pipeline while a fetch is
// in flight.
//
// Build option:
//   IMEM_AXI_RESP_CHECK_EN - when defined, an accepted beat with SLVERR or
//   DECERR loads a NOP into imem_rdata and sets the sticky fetch_err flag.
//   When undefined, RRESP is ignored and fetch_err is tied low.
//
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   imem_addr, imem_ren    fetch address and request from the core
//   imem_rdata             last fetched instruction (NOP after reset)
//   imem_raddr_handshake   pulse on the AR handshake
//   imem_rdata_handshake   pulse in the cycle imem_rdata presents new data
//   fetch_stall            high while a fetch is pending
//   fetch_err              sticky response-error flag
//   AR* / R*               AXI4 read address and read data channels
// -----------------------------------------------------------------------------
module imem_axi_read_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MASTER_ID = 0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ren,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_raddr_handshake,
  output logic              imem_rdata_handshake,
  output logic              fetch_stall,
  output logic              fetch_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_arvalid;
  logic              r_rready;
  logic [DATA_W-1:0] r_rdata;
  logic              w_ar_hs;
  logic              w_r_hs;

  // ARVALID/RREADY are flops that mirror "state is ADDR/DATA", so the
  // handshakes can be qualified by them directly.
  assign w_ar_hs = r_arvalid & ARREADY;
  assign w_r_hs  = r_rready  & RVALID;

  // ---------------------------------------------------------------------------
  // State register (plus registered state decodes for ARVALID / RREADY)
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_state   <= w_next_state;
      r_arvalid <= (w_next_state == S_ADDR);
      r_rready  <= (w_next_state == S_DATA);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path through the case leaves the signal
    // unassigned, which would infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (imem_ren) w_next_state = S_ADDR;
      S_ADDR:  if (w_ar_hs)  w_next_state = S_DATA;
      // ARLEN=0: the first accepted beat is the last one, RLAST not needed.
      S_DATA:  if (w_r_hs)   w_next_state = S_DONE;
      S_DONE:                w_next_state = S_IDLE;
      default:               w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_raddr_handshake = w_ar_hs;
    imem_rdata_handshake = (r_state == S_DONE);
    fetch_stall          = (r_state == S_ADDR) || (r_state == S_DATA) ||
                           ((r_state == S_IDLE) && imem_ren);
  end

  // Fetch address is captured word-aligned, only when leaving IDLE, so later
  // PC changes cannot disturb an outstanding request.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr <= '0;
    end else if ((r_state == S_IDLE) && imem_ren) begin
      r_addr <= {imem_addr[ADDR_W-1:2], 2'b00};
    end
  end

  // Returned instruction. It is architecturally visible right after reset,
  // so it resets to a NOP rather than being left undefined.
  // NOTE: this data register is reset on purpose; plain storage arrays
  // without architectural reset values are normally left unreset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rdata <= NOP_INSN;
    end else if (w_r_hs) begin
`ifdef IMEM_AXI_RESP_CHECK_EN
      r_rdata <= RRESP[1] ? NOP_INSN : RDATA;
`else
      r_rdata <= RDATA;
`endif
    end
  end

`ifdef IMEM_AXI_RESP_CHECK_EN
  logic r_fetch_err;

  // SLVERR (2'b10) and DECERR (2'b11) both have RRESP[1] set.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_fetch_err <= 1'b0;
    end else if (w_r_hs && RRESP[1]) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;

  logic w_unused;
  assign w_unused = ^{RID, RLAST, imem_addr[1:0]};
`else
  assign fetch_err = 1'b0;

  logic w_unused;
  assign w_unused = ^{RID, RLAST, RRESP, imem_addr[1:0]};
`endif

  assign imem_rdata = r_rdata;
  assign ARID       = ID_W'(MASTER_ID);
  assign ARADDR     = r_addr;
  assign ARLEN      = 8'd0;
  assign ARSIZE     = 3'b010;
  assign ARBURST    = 2'b01;
  assign ARVALID    = r_arvalid;
  assign RREADY     = r_rready;

endmodule

// File: tb/tb_imem_axi_read_master.sv
// -----------------------------------------------------------------------------
// tb_imem_axi_read_master
//
// Directed bench for imem_axi_read_master. Each fetch is described by its
// address, AR wait count, R wait count, data and response; the expected
// per-cycle output trace is derived from those numbers (latency =
// 4 + ar_wait + r_wait) and compared on every falling edge. A few literal
// expectations pin the model. Define IMEM_AXI_RESP_CHECK_EN for both bench
// and RTL to exercise the response-check build.
// -----------------------------------------------------------------------------
module tb_imem_axi_read_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IMEM_AXI_RESP_CHECK_EN
  localparam bit RESP_CHK = 1'b1;
`else
  localparam bit RESP_CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ren;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_raddr_handshake;
  logic              imem_rdata_handshake;
  logic              fetch_stall;
  logic              fetch_err;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  imem_axi_read_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MASTER_ID(0)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .imem_addr(imem_addr), .imem_ren(imem_ren),
    .imem_rdata(imem_rdata),
    .imem_raddr_handshake(imem_raddr_handshake),
    .imem_rdata_handshake(imem_rdata_handshake),
    .fetch_stall(fetch_stall), .fetch_err(fetch_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: expected outputs for the current cycle.
  bit          chk_en = 1'b0;
  logic [31:0] m_addr;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        e_arvalid, e_rready, e_ahs, e_dhs, e_stall;

  task automatic model_reset();
    m_addr = '0; m_rdata = NOP; m_err = 1'b0;
    e_arvalid = 1'b0; e_rready = 1'b0; e_ahs = 1'b0; e_dhs = 1'b0; e_stall = 1'b0;
  endtask

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ARVALID",  {31'd0, ARVALID},              {31'd0, e_arvalid});
      check("RREADY",   {31'd0, RREADY},               {31'd0, e_rready});
      check("AR_HS",    {31'd0, imem_raddr_handshake}, {31'd0, e_ahs});
      check("R_HS",     {31'd0, imem_rdata_handshake}, {31'd0, e_dhs});
      check("STALL",    {31'd0, fetch_stall},          {31'd0, e_stall});
      check("ARADDR",   ARADDR,                        m_addr);
      check("RDATA_OUT", imem_rdata,                   m_rdata);
      check("FETCH_ERR", {31'd0, fetch_err},           {31'd0, m_err});
      check("ARLEN",    {24'd0, ARLEN},                32'd0);
      check("ARSIZE",   {29'd0, ARSIZE},               32'd2);
      check("ARBURST",  {30'd0, ARBURST},              32'd1);
      check("ARID",     {28'd0, ARID},                 32'd0);
    end
  end

  // Idle cycles: no request, slave side noisy (must be ignored).
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      imem_ren = 1'b0; imem_addr = $urandom;
      ARREADY = 1'b1; RVALID = 1'b1; RDATA = $urandom; RRESP = 2'b10; RLAST = 1'b1;
      e_arvalid = 1'b0; e_rready = 1'b0; e_ahs = 1'b0; e_dhs = 1'b0; e_stall = 1'b0;
    end
  endtask

  // One fetch. eager: ARREADY/RVALID high from the request cycle (zero waits).
  // abort_c >= 0: assert reset asynchronously inside cycle abort_c.
  task automatic fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                       input logic [31:0] data, input logic [1:0] resp,
                       input bit eager, input int abort_c, output int lat);
    int len, dcyc;
    len  = 4 + ar_wait + r_wait;
    dcyc = 2 + ar_wait + r_wait;   // cycle in which the beat is accepted
    lat  = -1;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      imem_ren  = (c == 0);
      imem_addr = (c == 0) ? addr : $urandom;
      ARREADY   = eager || (c >= 1 + ar_wait);
      RVALID    = eager || (c >= dcyc);
      RDATA     = (c == dcyc) ? data : $urandom;
      RRESP     = (c == dcyc) ? resp : 2'b11;
      RLAST     = 1'b1;
      if (c == 1) m_addr = {addr[31:2], 2'b00};
      e_stall   = (c < len - 1);
      e_arvalid = (c >= 1) && (c <= 1 + ar_wait);
      e_ahs     = (c == 1 + ar_wait);
      e_rready  = (c >= 2 + ar_wait) && (c <= dcyc);
      e_dhs     = (c == len - 1);
      if (c == len - 1) begin
        m_rdata = (RESP_CHK && resp[1]) ? NOP : data;
        if (RESP_CHK && resp[1]) m_err = 1'b1;
      end
      if (c == abort_c) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("ASYNC_ARVALID", {31'd0, ARVALID}, 32'd0);
        check("ASYNC_RREADY",  {31'd0, RREADY},  32'd0);
        check("ASYNC_RDATA",   imem_rdata,       NOP);
        @(negedge clk);
        return;
      end
      @(negedge clk);
      if (lat < 0 && imem_rdata_handshake) lat = c + 1;
    end
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    imem_ren = 1'b0; imem_addr = '0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RID = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Out of reset with no request: 10 quiet cycles.
    idle(10);

    // Zero-wait fetch, slave ready/valid from the start.
    fetch(32'h0000_0104, 0, 0, 32'h0050_0093, 2'b00, 1'b1, -1, lat);
    check("LAT_ZERO_WAIT", lat, 32'd4);
    check("LIT_RDATA",  imem_rdata, 32'h0050_0093);
    check("LIT_ARADDR", ARADDR,     32'h0000_0104);
    idle(2);

    // Backpressure: 3 AR wait cycles, 2 R wait cycles.
    fetch(32'h0000_1000, 3, 2, 32'h1234_5678, 2'b00, 1'b0, -1, lat);
    check("LAT_BACKPRESSURE", lat, 32'd9);
    idle(1);

    // Unaligned request address.
    fetch(32'h0000_0107, 0, 0, 32'hA5A5_0001, 2'b00, 1'b0, -1, lat);
    check("LIT_UNALIGNED", ARADDR, 32'h0000_0104);

    // Back-to-back fetch straight after DONE.
    fetch(32'h0000_0200, 1, 0, 32'h0000_0517, 2'b00, 1'b0, -1, lat);
    check("LAT_B2B", lat, 32'd5);
    idle(1);

    // SLVERR response, then an OKAY fetch (error flag sticky when enabled).
    fetch(32'h0000_0300, 0, 1, 32'hDEAD_BEEF, 2'b10, 1'b0, -1, lat);
    check("LIT_SLVERR_RDATA", imem_rdata, RESP_CHK ? NOP : 32'hDEAD_BEEF);
    check("LIT_SLVERR_ERR", {31'd0, fetch_err}, {31'd0, RESP_CHK});
    fetch(32'h0000_0304, 0, 0, 32'h0010_0073, 2'b00, 1'b0, -1, lat);
    check("LIT_ERR_STICKY", {31'd0, fetch_err}, {31'd0, RESP_CHK});
    fetch(32'h0000_0308, 0, 0, 32'hCAFE_F00D, 2'b11, 1'b0, -1, lat);
    idle(2);

    // Reset during DATA (beat would arrive later); nothing must be captured.
    fetch(32'h0000_0400, 0, 5, 32'h7777_7777, 2'b00, 1'b0, 4, lat);
    @(posedge clk); #1;
    imem_ren = 1'b0; ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'h7777_7777;
    rst_n = 1'b1;
    idle(5);
    check("LIT_AFTER_RESET", imem_rdata, NOP);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
